rr_grant_arbiter: RTL and testbench

- 16-requester round-robin arbiter that produces a registered one-hot grant vector.
- Sits directly upstream of the 16:4 one-hot encoder, which converts the grant into a 4-bit requester index for the datapath mux.
- Holds each grant until the consumer acknowledges it, then rotates priority so no requester starves.

---
 rtl/rr_grant_arbiter_pkg.sv | 24 ++
 rtl/rr_grant_arbiter_if.sv | 38 +++
 rtl/rr_grant_arbiter_pick16.sv | 45 ++++
 rtl/rr_grant_arbiter.sv | 146 ++++++++++++++
 tb/tb_rr_grant_arbiter.sv | 134 +++++++++++++
 5 files changed

// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and constants for the 16-requester round-robin grant arbiter.
// Optional grant timeout is enabled with the ARB_TIMEOUT_EN macro.
package rr_grant_arbiter_pkg;

  localparam int N           = 16;
  localparam int PW          = 4;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  // Priority moves to the requester just after the one last served; wraps 15 -> 0.
  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] sel);
    return sel + {{(PW-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic is_onehot_or_zero(input logic [N-1:0] v);
    return ((v & (v - {{(N-1){1'b0}}, 1'b1})) == {N{1'b0}});
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant handshake bundle between requesters/consumer and the arbiter.
// timeout_err exists only when ARB_TIMEOUT_EN is defined.
interface rr_grant_arbiter_if
  import rr_grant_arbiter_pkg::*;
();

  logic [N-1:0] req;
  logic         grant_ack;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic         busy;
`ifdef ARB_TIMEOUT_EN
  logic         timeout_err;
`endif

  modport master (
    output req,
    output grant_ack,
    input  grant,
    input  grant_valid,
`ifdef ARB_TIMEOUT_EN
    input  timeout_err,
`endif
    input  busy
  );

  modport slave (
    input  req,
    input  grant_ack,
    output grant,
    output grant_valid,
`ifdef ARB_TIMEOUT_EN
    output timeout_err,
`endif
    output busy
  );

endinterface

// File: rtl/rr_grant_arbiter_pick16.sv
// Combinational rotate-and-select: first set request at or after ptr, wrapping mod 16.
// Returns a one-hot pick (zero when no request) and its index.
module rr_grant_arbiter_pick16
  import rr_grant_arbiter_pkg::*;
(
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  pick_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  logic          found_s;
  logic [PW-1:0] idx_s;
  logic [PW-1:0] pos_s;

  // Scan from ptr upward; the first hit stops further updates.
  always_comb begin
    found_s = 1'b0;
    idx_s   = {PW{1'b0}};
    pos_s   = {PW{1'b0}};
    for (int i = 0; i < N; i++) begin
      pos_s = ptr_i + PW'(i);
      if (!found_s && req_i[pos_s]) begin
        found_s = 1'b1;
        idx_s   = pos_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot form of the selected index; all-zero when nothing requests.
  always_comb begin
    if (found_s) begin
      pick_o = {{(N-1){1'b0}}, 1'b1} << idx_s;
    end else begin
      pick_o = {N{1'b0}};
    end
  end

  assign idx_o   = idx_s;
  assign valid_o = found_s;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a registered one-hot grant held until acknowledged.
// With ARB_TIMEOUT_EN defined, an unacknowledged grant is revoked after TIMEOUT cycles.
module rr_grant_arbiter
  import rr_grant_arbiter_pkg::*;
#(
`ifdef ARB_TIMEOUT_EN
  parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_grant_arbiter_if.slave bus
);

  arb_state_e    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] sel_q, sel_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          grant_valid_q, grant_valid_d;
  logic          busy_q, busy_d;

  logic [N-1:0]  pick_s;
  logic [PW-1:0] pick_idx_s;
  logic          pick_valid_s;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_err_q, timeout_err_d;
`endif

  rr_grant_arbiter_pick16 u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .pick_o  (pick_s),
    .idx_o   (pick_idx_s),
    .valid_o (pick_valid_s)
  );

  // Next-state and output decode for IDLE -> GRANT -> RELEASE.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    sel_d         = sel_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          grant_d       = pick_s;
          grant_valid_d = 1'b1;
          sel_d         = pick_idx_s;
          state_d       = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
          cnt_d         = {CW{1'b0}};
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // req is deliberately ignored here: the grant is sticky until ack.
        if (bus.grant_ack) begin
          ptr_d         = ptr_after(sel_q);
          grant_d       = {N{1'b0}};
          grant_valid_d = 1'b0;
          state_d       = ST_RELEASE;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          ptr_d         = ptr_after(sel_q);
          grant_d       = {N{1'b0}};
          grant_valid_d = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
`else
        end else begin
          state_d = ST_GRANT;
        end
`endif
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d       = ST_IDLE;
        grant_d       = {N{1'b0}};
        grant_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    // Never let a multi-hot value reach the encoder, even on corrupted state.
    if (!is_onehot_or_zero(grant_d)) begin
      grant_d       = {N{1'b0}};
      grant_valid_d = 1'b0;
    end else begin
      grant_valid_d = grant_valid_d;
    end
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= {PW{1'b0}};
      sel_q         <= {PW{1'b0}};
      grant_q       <= {N{1'b0}};
      grant_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      sel_q         <= sel_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      busy_q        <= busy_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Grant wait counter and one-cycle revocation pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= {CW{1'b0}};
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`endif

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: reset, rotation, fairness, sticky grant,
// async reset mid-grant, ignored idle ack, and (with ARB_TIMEOUT_EN) revocation.
module tb_rr_grant_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  rr_grant_arbiter_if arb_if ();

`ifdef ARB_TIMEOUT_EN
  rr_grant_arbiter #(.TIMEOUT(4)) dut (
`else
  rr_grant_arbiter dut (
`endif
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (arb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expect exp granted now, ack it, walk RELEASE and IDLE, then arbitrate next_req.
  task automatic grant_cycle(input logic [15:0] exp, input logic [15:0] next_req);
    chk("grant", arb_if.grant, exp);
    chk("grant_valid", {15'd0, arb_if.grant_valid}, 16'd1);
    chk("busy_grant", {15'd0, arb_if.busy}, 16'd1);
    arb_if.grant_ack = 1'b1;
    tick();
    arb_if.grant_ack = 1'b0;
    arb_if.req       = next_req;
    chk("release_grant", arb_if.grant, 16'h0000);
    chk("release_valid", {15'd0, arb_if.grant_valid}, 16'd0);
    chk("release_busy", {15'd0, arb_if.busy}, 16'd1);
    tick();
    chk("idle_grant", arb_if.grant, 16'h0000);
    chk("idle_busy", {15'd0, arb_if.busy}, 16'd0);
    tick();
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    rst_n            = 1'b0;
    arb_if.req       = 16'hFFFF;
    arb_if.grant_ack = 1'b0;
    tick();
    tick();
    chk("rst_grant", arb_if.grant, 16'h0000);
    chk("rst_valid", {15'd0, arb_if.grant_valid}, 16'd0);
    chk("rst_busy", {15'd0, arb_if.busy}, 16'd0);
    rst_n = 1'b1;
    tick();

    // Full rotation 0..15 then wrap to 0; last release leaves ptr=1.
    for (int i = 0; i < 16; i++) begin
      grant_cycle(16'h0001 << i, 16'hFFFF);
    end
    grant_cycle(16'h0001, 16'h8001);

    // Sparse fairness: ptr=1 so bit 15 wins first, then alternation.
    grant_cycle(16'h8000, 16'h8001);
    grant_cycle(16'h0001, 16'h8001);
    grant_cycle(16'h8000, 16'h0010);

    // Sticky grant while req drops to zero.
    arb_if.req = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      chk("sticky_grant", arb_if.grant, 16'h0010);
      tick();
    end
    grant_cycle(16'h0010, 16'h0000);
    chk("empty_idle_grant", arb_if.grant, 16'h0000);
    chk("empty_idle_busy", {15'd0, arb_if.busy}, 16'd0);

    // ptr=5 now, so 0x0400 is picked; async reset must drop it immediately.
    arb_if.req = 16'h0401;
    tick();
    chk("pre_rst_grant", arb_if.grant, 16'h0400);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_grant", arb_if.grant, 16'h0000);
    chk("async_rst_valid", {15'd0, arb_if.grant_valid}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    grant_cycle(16'h0001, 16'h0000);

    // Ack while idle is ignored, and ack alongside req in IDLE still arbitrates.
    arb_if.grant_ack = 1'b1;
    tick();
    chk("idle_ack_grant", arb_if.grant, 16'h0000);
    chk("idle_ack_busy", {15'd0, arb_if.busy}, 16'd0);
    arb_if.req = 16'h0002;
    tick();
    arb_if.grant_ack = 1'b0;
    grant_cycle(16'h0002, 16'h0003);

`ifdef ARB_TIMEOUT_EN
    // ptr=2 with req 0x0003 wraps to requester 0; no ack, revoked after 4 cycles.
    for (int i = 0; i < 4; i++) begin
      chk("to_hold_grant", arb_if.grant, 16'h0001);
      chk("to_no_err", {15'd0, arb_if.timeout_err}, 16'd0);
      tick();
    end
    chk("to_revoked", arb_if.grant, 16'h0000);
    chk("to_err_pulse", {15'd0, arb_if.timeout_err}, 16'd1);
    tick();
    chk("to_err_clear", {15'd0, arb_if.timeout_err}, 16'd0);
    tick();
    grant_cycle(16'h0002, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
